// File: rtl/mem_line_ctrl.sv
// Word-to-line load / read-modify-write store controller, one request in flight; ready only when idle.
// Load answers two cycles after acceptance, store three; optional MEM_LINE_BUF_EN line buffer answers load hits in one.
module mem_line_ctrl #(
  parameter int BITSIZE          = 32,
  parameter int N_WORDS_PER_ADDR = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn_i,
  input  logic [31:0]                           req_addr_i,
  input  logic [BITSIZE-1:0]                    req_data_i,
  input  logic [BITSIZE/8-1:0]                  req_be_i,
  input  logic                                  req_we_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  output logic [BITSIZE-1:0]                    rsp_data_o,
  output logic                                  rsp_valid_o,
  output logic [31:0]                           mem_addr_o,
  output logic [N_WORDS_PER_ADDR*BITSIZE-1:0]   mem_data_o,
  input  logic [N_WORDS_PER_ADDR*BITSIZE-1:0]   mem_data_i,
  output logic                                  mem_store_o,
  output logic                                  mem_valid_o,
  input  logic                                  mem_valid_i
);

  localparam int LINE_W = N_WORDS_PER_ADDR * BITSIZE;
  localparam int BE_W   = BITSIZE / 8;
  localparam int WSEL_W = $clog2(N_WORDS_PER_ADDR);
  localparam int OFFS   = WSEL_W + 2;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:2]         addr_q;
  logic [BITSIZE-1:0]  data_q;
  logic [BE_W-1:0]     be_q;
  logic                we_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   merged;
  logic [WSEL_W-1:0]   wsel;
  logic                buf_hit;
  logic                unused_addr_lsb;

  // Byte offset within a word carries no meaning here.
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign wsel = addr_q[OFFS-1:2];

  always_comb begin
    merged = line_q;
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) merged[int'(wsel)*BITSIZE + b*8 +: 8] = data_q[b*8 +: 8];
    end
  end

`ifdef MEM_LINE_BUF_EN
  logic                buf_vld;
  logic [31:OFFS]      buf_tag;
  logic [LINE_W-1:0]   buf_line;

  assign buf_hit = !req_we_i && buf_vld && (buf_tag == req_addr_i[31:OFFS]);

  // Write-through: the buffer tracks whatever line last went to or came from memory.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_line <= '0;
    end else if (state == RD && mem_valid_i) begin
      buf_vld  <= 1'b1;
      buf_tag  <= addr_q[31:OFFS];
      buf_line <= mem_data_i;
    end else if (state == WR && mem_valid_i) begin
      buf_vld  <= 1'b1;
      buf_tag  <= addr_q[31:OFFS];
      buf_line <= merged;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    mem_valid_o = 1'b0;
    mem_store_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = buf_hit ? RESP : RD;
      end
      RD: begin
        mem_valid_o = 1'b1;
        if (mem_valid_i) state_nxt = we_q ? WR : RESP;
      end
      WR: begin
        mem_valid_o = 1'b1;
        mem_store_o = 1'b1;
        if (mem_valid_i) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      we_q   <= 1'b0;
      line_q <= '0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        addr_q <= req_addr_i[31:2];
        data_q <= req_data_i;
        be_q   <= req_be_i;
        we_q   <= req_we_i;
`ifdef MEM_LINE_BUF_EN
        if (buf_hit) line_q <= buf_line;
`endif
      end
      if (state == RD && mem_valid_i) line_q <= mem_data_i;
      // Keep the merged line so the response returns the word as written.
      if (state == WR && mem_valid_i) line_q <= merged;
    end
  end

  assign rsp_data_o = (state == RESP) ? line_q[int'(wsel)*BITSIZE +: BITSIZE] : '0;
  assign mem_addr_o = (state == RD || state == WR) ? {addr_q[31:OFFS], {OFFS{1'b0}}} : '0;
  assign mem_data_o = (state == WR) ? merged : '0;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl: directed vector table, hand sequences for reset and held requests, random traffic vs a word-level model.
module tb_mem_line_ctrl;

  logic         clk;
  logic         resetn_i;
  logic [31:0]  req_addr_i;
  logic [31:0]  req_data_i;
  logic [3:0]   req_be_i;
  logic         req_we_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  rsp_data_o;
  logic         rsp_valid_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_store_o;
  logic         mem_valid_o;
  logic         mem_valid_i;

  mem_line_ctrl #(.BITSIZE(32), .N_WORDS_PER_ADDR(4)) dut (
    .clk(clk), .resetn_i(resetn_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_be_i(req_be_i),
    .req_we_i(req_we_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_store_o(mem_store_o), .mem_valid_o(mem_valid_o), .mem_valid_i(mem_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the controller: 16 lines of 4 words, indexed by address bits [7:4].
  logic [31:0] mem_w [64];
  assign mem_data_i = {mem_w[{mem_addr_o[7:4], 2'd3}], mem_w[{mem_addr_o[7:4], 2'd2}],
                       mem_w[{mem_addr_o[7:4], 2'd1}], mem_w[{mem_addr_o[7:4], 2'd0}]};

  always @(posedge clk) begin
    if (mem_valid_o && mem_store_o && mem_valid_i) begin
      for (int w = 0; w < 4; w++) mem_w[{mem_addr_o[7:4], 2'(w)}] <= mem_data_o[w*32 +: 32];
    end
  end

  // Reference: flat word memory plus the tag of the last line that went through memory.
  logic [31:0] ref_w [64];
  logic        ref_bv;
  logic [27:0] ref_tag;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic we, output logic [31:0] rsp, output logic hit);
    int wi;
    wi  = int'(a[7:2]);
    hit = 1'b0;
`ifdef MEM_LINE_BUF_EN
    hit = !we && ref_bv && (ref_tag == a[31:4]);
`endif
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_w[wi][b*8 +: 8] = d[b*8 +: 8];
    end
    rsp = ref_w[wi];
    if (!hit) begin
      ref_bv  = 1'b1;
      ref_tag = a[31:4];
    end
  endtask

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    return {ref_w[{a[7:4], 2'd3}], ref_w[{a[7:4], 2'd2}], ref_w[{a[7:4], 2'd1}], ref_w[{a[7:4], 2'd0}]};
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic we, input int stall, input logic [31:0] exp_rsp,
                         input int exp_lat, input logic [127:0] exp_line, input string nm);
    int lat, rd_seen;
    logic [31:0]  got;
    logic [127:0] wr_line;
    logic saw_store, saw_mem, addr_bad, ready_bad;
    lat = 0; rd_seen = 0; got = '0; wr_line = '0;
    saw_store = 0; saw_mem = 0; addr_bad = 0; ready_bad = 0;
    @(posedge clk); #1;
    req_addr_i = a; req_data_i = d; req_be_i = be; req_we_i = we; req_valid_i = 1'b1;
    chk({nm, "_ready"}, 128'(req_ready_o), 128'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_valid_o) begin
        saw_mem = 1'b1;
        if (mem_addr_o !== {a[31:4], 4'h0}) addr_bad = 1'b1;
        if (mem_store_o) begin
          saw_store = 1'b1;
          wr_line   = mem_data_o;
        end
      end
      if (mem_valid_o && !mem_store_o && rd_seen < stall) begin
        mem_valid_i = 1'b0;
        rd_seen++;
      end else begin
        mem_valid_i = 1'b1;
      end
      if (rsp_valid_o) begin
        lat = k;
        got = rsp_data_o;
      end else if (req_ready_o) begin
        ready_bad = 1'b1;
      end
    end
    mem_valid_i = 1'b1;
    @(negedge clk);
    chk({nm, "_pulse"}, {126'd0, rsp_valid_o, req_ready_o}, 128'b01);
    chk({nm, "_rsp"}, 128'(got), 128'(exp_rsp));
    chk({nm, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({nm, "_store_seen"}, 128'(saw_store), 128'(we));
    chk({nm, "_mem_seen"}, 128'(saw_mem), 128'(exp_lat != 1));
    chk({nm, "_addr_stable"}, 128'(addr_bad), 128'd0);
    chk({nm, "_ready_busy"}, 128'(ready_bad), 128'd0);
    if (we) chk({nm, "_wline"}, wr_line, exp_line);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
    int          stall;
    logic [31:0] rsp;
    int          lat_nobuf;
    int          lat_buf;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] e1, e2, d1, d2, ra, rd;
    logic        h1, h2;
    logic [3:0]  rbe, line, prev_line;
    logic        rwe, bad;
    int          t1, t2, rd_seen, lat, stall, bad_cnt;

    vecs[0]  = '{32'h0000_0004, 32'h0,        4'h0, 1'b0, 0, 32'h0021_8193, 2, 2};
    vecs[1]  = '{32'h0000_0008, 32'hAABBCCDD, 4'h3, 1'b1, 0, 32'h1122_CCDD, 3, 3};
    vecs[2]  = '{32'h0000_0008, 32'h0,        4'h0, 1'b0, 0, 32'h1122_CCDD, 2, 1};
    vecs[3]  = '{32'h0000_0010, 32'h0,        4'h0, 1'b0, 0, 32'h5000_0404, 2, 2};
    vecs[4]  = '{32'h0000_0014, 32'h0,        4'h0, 1'b0, 0, 32'h5000_0505, 2, 1};
    vecs[5]  = '{32'h0000_0020, 32'hCAFEF00D, 4'hF, 1'b1, 0, 32'hCAFE_F00D, 3, 3};
    vecs[6]  = '{32'h0000_0020, 32'h0,        4'h0, 1'b0, 0, 32'hCAFE_F00D, 2, 1};
    vecs[7]  = '{32'h0000_0024, 32'hFFFFFFFF, 4'h0, 1'b1, 0, 32'h5000_0909, 3, 3};
    vecs[8]  = '{32'h0000_0027, 32'h0,        4'h0, 1'b0, 0, 32'h5000_0909, 2, 1};
    vecs[9]  = '{32'h0000_0030, 32'h0,        4'h0, 1'b0, 5, 32'h5000_0C0C, 7, 7};
    vecs[10] = '{32'h0000_0034, 32'h77000000, 4'h8, 1'b1, 3, 32'h7700_0D0D, 6, 6};
    vecs[11] = '{32'hDEAD_BEE4, 32'h0,        4'h0, 1'b0, 0, 32'h5000_3939, 2, 2};

    for (int i = 0; i < 64; i++) begin
      mem_w[i] <= 32'h5000_0000 + i * 32'h0101;
      ref_w[i]  = 32'h5000_0000 + i * 32'h0101;
    end
    mem_w[1] <= 32'h0021_8193; ref_w[1] = 32'h0021_8193;
    mem_w[2] <= 32'h1122_3344; ref_w[2] = 32'h1122_3344;
    ref_bv = 1'b0; ref_tag = '0;

    resetn_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_be_i = '0;
    req_we_i = 1'b0; req_valid_i = 1'b0; mem_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 128'(req_ready_o), 128'd1);
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("rst_rsp_data", 128'(rsp_data_o), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr_o), 128'd0);
    chk("rst_mem_data", mem_data_o, 128'd0);
    chk("rst_mem_ctl", {126'd0, mem_store_o, mem_valid_o}, 128'd0);
    resetn_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      model(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].we, e1, h1);
`ifdef MEM_LINE_BUF_EN
      lat = vecs[i].lat_buf;
`else
      lat = vecs[i].lat_nobuf;
`endif
      run_txn(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].we, vecs[i].stall,
              vecs[i].rsp, lat, ref_line(vecs[i].addr), $sformatf("vec%0d", i));
    end

    // Request held valid while busy: the changed fields must wait for IDLE.
    model(32'hE8, 32'h0, 4'h0, 1'b0, e1, h1);
    model(32'hEC, 32'h12345678, 4'hF, 1'b1, e2, h2);
    @(posedge clk); #1;
    req_addr_i = 32'hE8; req_data_i = '0; req_be_i = '0; req_we_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_addr_i = 32'hEC; req_data_i = 32'h12345678; req_be_i = 4'hF; req_we_i = 1'b1;
    t1 = 0; t2 = 0; d1 = '0; d2 = '0; rd_seen = 0;
    for (int k = 1; k <= 30 && t2 == 0; k++) begin
      @(negedge clk);
      if (mem_valid_o && !mem_store_o && rd_seen < 2) begin
        mem_valid_i = 1'b0;
        rd_seen++;
      end else begin
        mem_valid_i = 1'b1;
      end
      if (rsp_valid_o) begin
        if (t1 == 0) begin t1 = k; d1 = rsp_data_o; end
        else begin t2 = k; d2 = rsp_data_o; end
      end
      if (t1 != 0 && !rsp_valid_o && !req_ready_o) req_valid_i = 1'b0;
    end
    req_valid_i = 1'b0; mem_valid_i = 1'b1;
    chk("held_t1", 128'(t1), 128'd4);
    chk("held_d1", 128'(d1), 128'h5000_3A3A);
    chk("held_t2", 128'(t2), 128'd8);
    chk("held_d2", 128'(d2), 128'(e2));

    // Reset while a store sits in RD.
    @(negedge clk);
    @(posedge clk); #1;
    req_addr_i = 32'h2C; req_data_i = 32'hDEADBEEF; req_be_i = 4'hF; req_we_i = 1'b1;
    req_valid_i = 1'b1; mem_valid_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rstrd_in_rd", {126'd0, mem_valid_o, mem_store_o}, 128'b10);
    #1 resetn_i = 1'b0;
    #1;
    chk("rstrd_ready", 128'(req_ready_o), 128'd1);
    chk("rstrd_outs", {rsp_valid_o, rsp_data_o, mem_addr_o, mem_store_o, mem_valid_o}, 128'd0);
    chk("rstrd_mem_data", mem_data_o, 128'd0);
    mem_valid_i = 1'b1;
    #1 resetn_i = 1'b1;
    ref_bv = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_store_o || rsp_valid_o || mem_valid_o) bad = 1'b1;
    end
    chk("rstrd_quiet", 128'(bad), 128'd0);
    chk("rstrd_mem_kept", 128'(mem_w[11]), 128'(ref_w[11]));

    prev_line = 4'h0;
    for (int i = 0; i < 60; i++) begin
      line  = $urandom_range(0, 1) ? prev_line : 4'($urandom);
      ra    = {24'h0, line, 4'($urandom)};
      rwe   = ($urandom_range(0, 2) == 0);
      rd    = $urandom;
      rbe   = 4'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      model(ra, rd, rbe, rwe, e1, h1);
      lat = rwe ? 3 + stall : (h1 ? 1 : 2 + stall);
      run_txn(ra, rd, rbe, rwe, stall, e1, lat, ref_line(ra), $sformatf("rnd%0d", i));
      prev_line = line;
    end

    @(negedge clk);
    bad_cnt = 0;
    for (int i = 0; i < 64; i++) if (mem_w[i] !== ref_w[i]) bad_cnt++;
    chk("mem_final", 128'(bad_cnt), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_line_ctrl.md
MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  BITSIZE, 32, word width in bits.
  N_WORDS_PER_ADDR, 4, words per memory line; line width = N_WORDS_PER_ADDR*BITSIZE (128 at defaults).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on the rising edge.
  resetn_i  in  1  asynchronous, active-low reset.
  req_addr_i  in  32  core byte address.
  req_data_i  in  BITSIZE  store data.
  req_be_i  in  BITSIZE/8  store byte enables.
  req_we_i  in  1  1 = store, 0 = load.
  req_valid_i  in  1  request valid.
  req_ready_o  out  1  controller can accept a request.
  rsp_data_o  out  BITSIZE  response word.
  rsp_valid_o  out  1  response valid, one-cycle pulse.
  mem_addr_o  out  32  line address to mem.
  mem_data_o  out  line  store line to mem.
  mem_data_i  in  line  load line from mem.
  mem_store_o  out  1  1 = store, 0 = load.
  mem_valid_o  out  1  mem request valid.
  mem_valid_i  in  1  mem request completed.

Function
REQ-003 The block SHALL accept a request on any rising edge where req_valid_i and req_ready_o are both 1, latching addr, data, be and we.
REQ-004 req_ready_o SHALL be 1 only in state IDLE.
REQ-005 The FSM SHALL have four states: IDLE, RD, WR and RESP.
REQ-006 On an accepted request, IDLE SHALL go to RD.
REQ-007 RD SHALL drive mem_valid_o=1 and mem_store_o=0, and SHALL hold while mem_valid_i=0.
REQ-008 On mem_valid_i=1 in RD, the block SHALL capture mem_data_i into the line register, then go to WR if we=1, else to RESP.
REQ-009 WR SHALL drive mem_valid_o=1, mem_store_o=1, and mem_data_o = the captured line with word addr[3:2] replaced bytewise wherever be[i]=1.
REQ-010 WR SHALL hold while mem_valid_i=0 and SHALL go to RESP on mem_valid_i=1.
REQ-011 RESP SHALL assert rsp_valid_o for exactly one cycle and SHALL then return to IDLE.
REQ-012 rsp_data_o in RESP SHALL be word addr[3:2] of the line register; for a store this is the merged word.
REQ-013 mem_addr_o SHALL be {addr[31:4], 4'b0}, held stable for the whole RD or WR state.
REQ-014 addr[1:0] SHALL be ignored; no alignment fault is raised.
REQ-015 Word select SHALL be addr[$clog2(N_WORDS_PER_ADDR)+1:2].
REQ-016 With mem_valid_i tied to 1: load accepted at edge N SHALL give rsp_valid_o in cycle N+2; store SHALL give it in cycle N+3.
REQ-017 A store with be=0 SHALL still perform the RD and WR accesses and SHALL write the unchanged line.
REQ-018 req_valid_i asserted outside IDLE SHALL be ignored; the core SHALL hold the request until ready.
REQ-019 mem_valid_o and mem_store_o SHALL be 0 in IDLE and RESP.

Reset
REQ-020 resetn_i=0 SHALL immediately force IDLE and clear all registers.
REQ-021 Reset values SHALL be: req_ready_o=1, and rsp_valid_o, rsp_data_o, mem_addr_o, mem_data_o, mem_store_o, mem_valid_o all 0.
REQ-022 A reset during RD or WR SHALL abandon the transaction with no response.
REQ-023 A reset during RD SHALL prevent the subsequent store from ever issuing.

Configuration
REQ-024 With macro MEM_LINE_BUF_EN defined, the block SHALL hold one line buffer (tag = addr[31:4], line data, valid bit); valid SHALL be cleared by reset.
REQ-025 With MEM_LINE_BUF_EN defined, a load hitting a valid buffer SHALL go IDLE->RESP without a mem access (rsp_valid_o in cycle N+1).
REQ-026 With MEM_LINE_BUF_EN defined, every RD completion SHALL fill the buffer.
REQ-027 With MEM_LINE_BUF_EN defined, every WR completion SHALL update the buffer with the merged line (write-through).
REQ-028 Stores SHALL always take the RD and WR path, with or without MEM_LINE_BUF_EN.
REQ-029 Without MEM_LINE_BUF_EN, no buffer SHALL exist and every load SHALL go through RD.

Verification
REQ-030 Load 0x4, mem line word1=0x00218193, mem_valid_i tied 1 -> rsp_data_o=0x00218193, rsp_valid_o in cycle N+2, mem_store_o never 1.
REQ-031 Store 0x8, data 0xAABBCCDD, be=4'b0011, old word 0x11223344 -> mem_data_o word2=0x1122CCDD; rsp_data_o=0x1122CCDD at N+3.
REQ-032 Load with mem_valid_i held 0 for 5 cycles in RD -> FSM stays RD, mem_addr_o stable, req_ready_o=0, response 5 cycles late.
REQ-033 resetn_i pulsed low in RD of a store -> all outputs 0 at once, no WR cycle, no rsp_valid_o, req_ready_o=1.
REQ-034 MEM_LINE_BUF_EN: two loads to 0x10 then 0x14 -> second gives rsp_valid_o at N+1 with mem_valid_o=0; without the macro both hit mem.
REQ-035 Store 0x20 then load 0x20 -> load returns the stored word, with and without MEM_LINE_BUF_EN.
